// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with occupancy count,
// almost-full/almost-empty flags and a synchronous flush.
module sync_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_LEVEL  = 12,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        io_flush,
  input  logic                        io_enq_valid,
  output logic                        io_enq_ready,
  input  logic [DATA_WIDTH-1:0]       io_enq_bits,
  input  logic                        io_deq_ready,
  output logic                        io_deq_valid,
  output logic [DATA_WIDTH-1:0]       io_deq_bits,
  output logic [$clog2(DEPTH):0]      io_count,
  output logic                        io_almostFull,
  output logic                        io_almostEmpty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_COUNT   = CNT_W'(ALMOST_FULL_LEVEL);
  localparam logic [CNT_W-1:0] AE_COUNT   = CNT_W'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_r;
  logic [ADDR_W-1:0]     rd_ptr_r;
  logic [ADDR_W-1:0]     wr_ptr_nxt_s;
  logic [ADDR_W-1:0]     rd_ptr_nxt_s;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_nxt_s;
  logic                  enq_fire_s;
  logic                  deq_fire_s;

  // Handshakes and flags: flush masks both sides; no full/empty bypass.
  always_comb begin
    io_enq_ready   = (count_r != FULL_COUNT) & ~io_flush;
    io_deq_valid   = (count_r != {CNT_W{1'b0}}) & ~io_flush;
    io_deq_bits    = mem_r[rd_ptr_r];
    io_count       = count_r;
    io_almostFull  = (count_r >= AF_COUNT);
    io_almostEmpty = (count_r <= AE_COUNT);
    enq_fire_s     = io_enq_valid & io_enq_ready;
    deq_fire_s     = io_deq_valid & io_deq_ready;
  end

  // Next pointer/occupancy state; flush overrides both handshakes.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (io_flush) begin
      wr_ptr_nxt_s = {ADDR_W{1'b0}};
      rd_ptr_nxt_s = {ADDR_W{1'b0}};
      count_nxt_s  = {CNT_W{1'b0}};
    end else begin
      if (enq_fire_s) begin
        wr_ptr_nxt_s = wr_ptr_r + ADDR_W'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (deq_fire_s) begin
        rd_ptr_nxt_s = rd_ptr_r + ADDR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({enq_fire_s, deq_fire_s})
        2'b10:   count_nxt_s = count_r + CNT_W'(1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (enq_fire_s) begin
      mem_r[wr_ptr_r] <= io_enq_bits;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed test-plan sequences plus randomized traffic, checked
// against a queue-based reference model of the FIFO.
module tb_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_flush;
  logic          io_enq_valid;
  logic          io_enq_ready;
  logic [DW-1:0] io_enq_bits;
  logic          io_deq_ready;
  logic          io_deq_valid;
  logic [DW-1:0] io_deq_bits;
  logic [CW-1:0] io_count;
  logic          io_almostFull;
  logic          io_almostEmpty;

  int n_checks = 0;
  int n_fails  = 0;
  logic [DW-1:0] model_q [$];

  sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .ALMOST_FULL_LEVEL(AF), .ALMOST_EMPTY_LEVEL(AE)
  ) dut (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready), .io_enq_bits(io_enq_bits),
    .io_deq_ready(io_deq_ready), .io_deq_valid(io_deq_valid), .io_deq_bits(io_deq_bits),
    .io_count(io_count), .io_almostFull(io_almostFull), .io_almostEmpty(io_almostEmpty)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: outputs are compared at the falling edge, then the
  // model applies the handshakes it predicted at the rising edge.
  task automatic cycle(input logic ev, input logic [DW-1:0] eb, input logic dr,
                       input logic fl, input logic rs);
    int   sz;
    logic exp_er;
    logic exp_dv;
    io_enq_valid = ev;
    io_enq_bits  = eb;
    io_deq_ready = dr;
    io_flush     = fl;
    reset        = rs;
    @(negedge clock);
    sz     = model_q.size();
    exp_er = (sz != DEPTH) && !fl;
    exp_dv = (sz != 0) && !fl;
    check_val("enq_ready", 64'(io_enq_ready), 64'(exp_er));
    check_val("deq_valid", 64'(io_deq_valid), 64'(exp_dv));
    check_val("count", 64'(io_count), 64'(sz));
    check_val("almost_full", 64'(io_almostFull), 64'(sz >= AF));
    check_val("almost_empty", 64'(io_almostEmpty), 64'(sz <= AE));
    if (exp_dv) check_val("deq_bits", 64'(io_deq_bits), 64'(model_q[0]));
    @(posedge clock);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (exp_dv && dr) void'(model_q.pop_front());
      if (exp_er && ev) model_q.push_back(eb);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; io_flush = 1'b0; io_enq_valid = 1'b0;
    io_enq_bits = '0; io_deq_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    model_q.delete();

    // reset then idle for 10 cycles
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // fill 0x00..0x0F, then a refused 17th write
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    check_val("full_count", 64'(io_count), 64'(DEPTH));
    cycle(1'b1, 32'hFF, 1'b0, 1'b0, 1'b0);
    check_val("full_after_17th", 64'(io_count), 64'(DEPTH));

    // drain in order
    for (int i = 0; i < DEPTH; i++) begin
      check_val("drain_order", 64'(io_deq_bits), 64'(i));
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    check_val("drained_valid", 64'(io_deq_valid), 64'(0));
    check_val("drained_count", 64'(io_count), 64'(0));

    // steady streaming at count=5 across pointer wrap
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(100 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, DW'(200 + i), 1'b1, 1'b0, 1'b0);
      check_val("stream_count", 64'(io_count), 64'(5));
    end
    while (model_q.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // single word latency
    cycle(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0);
    check_val("a5_valid", 64'(io_deq_valid), 64'(1));
    check_val("a5_bits", 64'(io_deq_bits), 64'(32'hA5));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // flush with concurrent handshakes
    for (int i = 0; i < 9; i++) cycle(1'b1, DW'(50 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
    check_val("flush_count", 64'(io_count), 64'(0));
    check_val("flush_valid", 64'(io_deq_valid), 64'(0));
    cycle(1'b1, 32'h3C, 1'b0, 1'b0, 1'b0);
    check_val("flush_first", 64'(io_deq_bits), 64'(32'h3C));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // reset in the middle of a transfer
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h11, 1'b1, 1'b0, 1'b1);
    check_val("rst_mid_count", 64'(io_count), 64'(0));

    // randomized traffic with biased phases to reach full and empty
    for (int ph = 0; ph < 6; ph++) begin
      int pe;
      int pd;
      pe = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 20 : 55);
      pd = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 85 : 55);
      for (int i = 0; i < 80; i++) begin
        cycle($urandom_range(0, 99) < pe, DW'($urandom), $urandom_range(0, 99) < pd,
              $urandom_range(0, 49) == 0, $urandom_range(0, 119) == 0);
      end
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Parametrised single-clock FIFO, the next generation of the dual-clock FIFO wrapper. It is a pure-RTL, first-word-fall-through FIFO with configurable width and depth, plus fill level, almost-full/almost-empty flags and a synchronous flush. It is used between the video/sprite pipeline stages and the memory arbiter where both sides share one clock and back-pressure needs early warning.

Parameters:
DATA_WIDTH, 32, width of each entry in bits (>=1).
DEPTH, 16, number of entries; power of two, >=2.
ALMOST_FULL_LEVEL, 12, io_almostFull asserts when count >= this value (1..DEPTH).
ALMOST_EMPTY_LEVEL, 2, io_almostEmpty asserts when count <= this value (0..DEPTH-1).

Ports:
clock  input  1  the single clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
io_flush  input  1  synchronous clear of all contents.
io_enq_valid  input  1  write request.
io_enq_ready  output  1  FIFO can accept a word.
io_enq_bits  input  DATA_WIDTH  write data.
io_deq_ready  input  1  consumer accepts head word.
io_deq_valid  output  1  head word present.
io_deq_bits  output  DATA_WIDTH  head word (FWFT).
io_count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
io_almostFull  output  1  count >= ALMOST_FULL_LEVEL.
io_almostEmpty  output  1  count <= ALMOST_EMPTY_LEVEL.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. On reset, wrPtr=rdPtr=0 and count=0. Resulting outputs: io_enq_ready=1, io_deq_valid=0, io_count=0, io_almostFull=0, io_almostEmpty=1. Storage contents are undefined after reset; io_deq_bits is don't-care while io_deq_valid=0.
- Storage: DEPTH x DATA_WIDTH array, written on rising edge. Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is held in a registered count.
- Enqueue fires when io_enq_valid & io_enq_ready. The data is written at wrPtr and wrPtr increments.
- Dequeue fires when io_deq_valid & io_deq_ready. rdPtr increments; io_deq_bits always shows mem[rdPtr] (asynchronous read, FWFT).
- io_enq_ready = (count != DEPTH) & ~io_flush. It has no combinational dependency on io_deq_ready, so enqueue is refused when full even if a dequeue fires in the same cycle.
- io_deq_valid = (count != 0) & ~io_flush. There is no bypass: a word written into an empty FIFO appears on io_deq_valid one cycle later, so enqueue-to-dequeue latency is 1 cycle.
- Simultaneous enqueue and dequeue (non-full, non-empty): both pointers advance and count is unchanged.
- Count update: +1 on enqueue only, -1 on dequeue only, unchanged otherwise. count never exceeds DEPTH and never goes below 0.
- Flags: io_almostFull and io_almostEmpty are combinational compares on the registered count, so they update in the same cycle as io_count.
- Flush: when io_flush=1, both pointers and count go to 0 on the next edge. Any enqueue/dequeue is suppressed that cycle because ready and valid are forced low. Flush takes priority over both handshakes; reset takes priority over flush.
- Reset asserted mid-transfer: in-flight handshakes are discarded and the state matches the power-on state on the next cycle.
- Not allowed (bench flags them; RTL need not guard): DEPTH not a power of two; ALMOST_FULL_LEVEL <= ALMOST_EMPTY_LEVEL.

Test Plan:
- Reset then idle -> enq_ready=1, deq_valid=0, count=0, almostEmpty=1, almostFull=0; hold for 10 cycles with no change.
- Write 0x00..0x0F (DEPTH=16, deq_ready=0) -> count climbs 1..16. almostFull rises on the cycle count=12. enq_ready=0 at count=16, and a 17th write of 0xFF is not accepted.
- Drain the full FIFO with deq_ready=1 -> deq_bits sequence 0x00..0x0F, one per cycle. deq_valid=0 after the last word, almostEmpty rises when count=2, count ends at 0.
- Continuous enq+deq at count=5 for 40 cycles (pointer wrap) -> count stays 5, output order matches input order, no loss or duplication.
- Single write 0xA5 into an empty FIFO -> deq_valid=0 in the write cycle and deq_valid=1 with deq_bits=0xA5 the next cycle.
- Fill to 9, then assert flush together with enq_valid/deq_ready -> that cycle enq_ready=0 and deq_valid=0. Next cycle count=0 and deq_valid=0. A subsequent write of 0x3C is read back as the first word.
